clock_period_monitor: RTL and testbench

Measures a slow, asynchronous clock (typically a divided clock from another domain or an external reference) in the CLK domain. It recovers single-cycle edge strobes, measures the period and high time in CLK cycles, and qualifies the input as locked or lost. It sits at the receiving end of divided-clock outputs and feeds status registers and downstream CE-driven logic.

---
 rtl/clock_period_monitor_if.sv | 32 +++
 rtl/clock_period_monitor.sv | 182 ++++++++++++++++++
 tb/tb_clock_period_monitor.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_period_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_period_monitor_if
// Brief    : Monitored-clock input plus strobe / measurement / status outputs
//            of the clock period monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface clock_period_monitor_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 CLK_IN;
   logic                 RISE_CE;
   logic                 FALL_CE;
   logic [CNT_WIDTH-1:0] PERIOD;
   logic [CNT_WIDTH-1:0] HIGH_TIME;
   logic                 PERIOD_VALID;
   logic                 LOCKED;
   logic                 LOST;

   // Monitor side: samples CLK_IN, produces strobes and status.
   modport master (
      input  CLK_IN,
      output RISE_CE, FALL_CE, PERIOD, HIGH_TIME, PERIOD_VALID, LOCKED, LOST
   );

   // Consumer side: supplies CLK_IN, observes strobes and status.
   modport slave (
      output CLK_IN,
      input  RISE_CE, FALL_CE, PERIOD, HIGH_TIME, PERIOD_VALID, LOCKED, LOST
   );
endinterface
`default_nettype wire

// File: rtl/clock_period_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clock_period_monitor
// Brief    : Synchronizes a slow asynchronous clock into the CLK domain,
//            emits rise/fall strobes, measures period and high time, and
//            qualifies the input as locked or lost.
// Revision : 1.0 - initial release
// ============================================================================
module clock_period_monitor #(
   parameter int CNT_WIDTH  = 16,
   parameter int TOLERANCE  = 1,
   parameter int LOCK_COUNT = 4
) (
   input  wire logic              CLK,
   input  wire logic              RESET,
   clock_period_monitor_if.master mon
);

   localparam int                   c_match_w    = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_WIDTH-1:0] c_cnt_max    = '1;
   localparam logic [CNT_WIDTH:0]   c_tol        = (CNT_WIDTH + 1)'(TOLERANCE);
   localparam logic [c_match_w-1:0] c_lock       = c_match_w'(LOCK_COUNT);

   localparam logic [1:0]           c_st_idle    = 2'd0;
   localparam logic [1:0]           c_st_measure = 2'd1;
   localparam logic [1:0]           c_st_track   = 2'd2;

   logic                 r_s1, r_s2, r_s3;
   logic                 r_rise_ce, r_fall_ce;
   logic [CNT_WIDTH-1:0] r_cnt, r_hcnt;
   logic [CNT_WIDTH-1:0] r_period, r_high_time;
   logic                 r_period_valid, r_locked, r_lost;
   logic [1:0]           r_state, w_state_nxt;
   logic [c_match_w-1:0] r_match;

   logic                 w_rise, w_fall, w_cnt_max;
   logic [CNT_WIDTH-1:0] w_period_new, w_high_new;
   logic [CNT_WIDTH:0]   w_a, w_b, w_diff;
   logic [c_match_w-1:0] w_match_nxt;

   logic w_period_load, w_valid_set, w_valid_clr, w_locked_set, w_locked_clr;
   logic w_match_clr, w_match_inc, w_lost_set, w_lost_clr, w_high_load;

   assign w_rise       = r_s2 & ~r_s3;
   assign w_fall       = ~r_s2 & r_s3;
   assign w_cnt_max    = (r_cnt == c_cnt_max);
   // Only consumed when cnt is below max, so the +1 cannot wrap.
   assign w_period_new = r_cnt + 1'b1;
   assign w_high_new   = (r_hcnt == c_cnt_max) ? c_cnt_max : r_hcnt + 1'b1;
   // One extra bit so the absolute difference never wraps.
   assign w_a          = {1'b0, w_period_new};
   assign w_b          = {1'b0, r_period};
   assign w_diff       = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
   assign w_match_nxt  = (r_match == c_lock) ? r_match : r_match + 1'b1;

   // Two-flop synchronizer, history flop and registered edge strobes.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_s3      <= 1'b0;
         r_rise_ce <= 1'b0;
         r_fall_ce <= 1'b0;
      end else begin
         r_s1      <= mon.CLK_IN;
         r_s2      <= r_s1;
         r_s3      <= r_s2;
         r_rise_ce <= w_rise;
         r_fall_ce <= w_fall;
      end
   end

   // Period and high-time counters: restart at each rise, saturate at max.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_cnt  <= '0;
         r_hcnt <= '0;
      end else if (w_rise) begin
         r_cnt  <= '0;
         r_hcnt <= '0;
      end else begin
         if (!w_cnt_max)            r_cnt  <= r_cnt + 1'b1;
         if (r_hcnt != c_cnt_max)   r_hcnt <= r_hcnt + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= c_st_idle;
      else       r_state <= w_state_nxt;
   end

   // Next state: a rise at saturation restarts measurement, saturation alone drops to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      if (w_rise) begin
         if (w_cnt_max) begin
            w_state_nxt = c_st_measure;
         end else begin
            case (r_state)
               c_st_idle:    w_state_nxt = c_st_measure;
               c_st_measure: w_state_nxt = c_st_track;
               c_st_track:   w_state_nxt = c_st_track;
               default:      w_state_nxt = c_st_idle;
            endcase
         end
      end else if (w_cnt_max) begin
         w_state_nxt = c_st_idle;
      end
   end

   // Output decode: per-cycle update commands for the measurement/status registers.
   always_comb begin
      w_period_load = 1'b0;
      w_valid_set   = 1'b0;
      w_valid_clr   = 1'b0;
      w_locked_set  = 1'b0;
      w_locked_clr  = 1'b0;
      w_match_clr   = 1'b0;
      w_match_inc   = 1'b0;
      w_lost_set    = 1'b0;
      w_lost_clr    = 1'b0;
      if (w_rise) begin
         w_lost_clr = 1'b1;
         if (w_cnt_max) begin
            w_valid_clr  = 1'b1;
            w_locked_clr = 1'b1;
         end else if (r_state == c_st_measure) begin
            w_period_load = 1'b1;
            w_valid_set   = 1'b1;
            w_match_clr   = 1'b1;
         end else if (r_state == c_st_track) begin
            w_period_load = 1'b1;
            if (w_diff <= c_tol) begin
               w_match_inc  = 1'b1;
               w_locked_set = (w_match_nxt == c_lock);
            end else begin
               w_match_clr  = 1'b1;
               w_locked_clr = 1'b1;
            end
         end
      end else if (w_cnt_max) begin
         w_lost_set   = 1'b1;
         w_locked_clr = 1'b1;
         w_valid_clr  = 1'b1;
      end
      w_high_load = w_fall && (r_state != c_st_idle);
   end

   // Measurement and status registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_period       <= '0;
         r_high_time    <= '0;
         r_period_valid <= 1'b0;
         r_locked       <= 1'b0;
         r_lost         <= 1'b0;
         r_match        <= '0;
      end else begin
         if (w_period_load) r_period    <= w_period_new;
         if (w_high_load)   r_high_time <= w_high_new;
         if (w_valid_set)        r_period_valid <= 1'b1;
         else if (w_valid_clr)   r_period_valid <= 1'b0;
         if (w_locked_set)       r_locked <= 1'b1;
         else if (w_locked_clr)  r_locked <= 1'b0;
         if (w_lost_set)         r_lost <= 1'b1;
         else if (w_lost_clr)    r_lost <= 1'b0;
         if (w_match_clr)        r_match <= '0;
         else if (w_match_inc)   r_match <= w_match_nxt;
      end
   end

   assign mon.RISE_CE      = r_rise_ce;
   assign mon.FALL_CE      = r_fall_ce;
   assign mon.PERIOD       = r_period;
   assign mon.HIGH_TIME    = r_high_time;
   assign mon.PERIOD_VALID = r_period_valid;
   assign mon.LOCKED       = r_locked;
   assign mon.LOST         = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_clock_period_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_period_monitor
// Brief    : Directed self-checking bench for clock_period_monitor
//            (CNT_WIDTH=8, TOLERANCE=1, LOCK_COUNT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_period_monitor;

   logic CLK;
   logic RESET;

   clock_period_monitor_if #(.CNT_WIDTH(8)) mon ();

   clock_period_monitor #(
      .CNT_WIDTH  (8),
      .TOLERANCE  (1),
      .LOCK_COUNT (4)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .mon   (mon)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Per-rise snapshots taken in the cycle RISE_CE is high, and the fall that follows it.
   int         rise_n;
   int         rise_cyc    [32];
   logic [7:0] rise_period [32];
   logic       rise_valid  [32];
   logic       rise_locked [32];
   logic       rise_lost   [32];
   int         fall_dt     [32];
   logic [7:0] fall_high   [32];

   task automatic clear_rec();
      rise_n = 0;
      for (int i = 0; i < 32; i++) begin
         rise_cyc[i]    = -1;
         rise_period[i] = 8'hxx;
         rise_valid[i]  = 1'bx;
         rise_locked[i] = 1'bx;
         rise_lost[i]   = 1'bx;
         fall_dt[i]     = -1;
         fall_high[i]   = 8'hxx;
      end
   endtask

   // Advance one CLK cycle, sample 1 time unit after the edge and log strobes.
   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
      if (mon.RISE_CE === 1'b1) begin
         if (rise_n < 32) begin
            rise_cyc[rise_n]    = cyc;
            rise_period[rise_n] = mon.PERIOD;
            rise_valid[rise_n]  = mon.PERIOD_VALID;
            rise_locked[rise_n] = mon.LOCKED;
            rise_lost[rise_n]   = mon.LOST;
         end
         rise_n++;
      end
      if (mon.FALL_CE === 1'b1 && rise_n > 0 && rise_n <= 32) begin
         fall_dt[rise_n-1]   = cyc - rise_cyc[rise_n-1];
         fall_high[rise_n-1] = mon.HIGH_TIME;
      end
   endtask

   task automatic drive_period(input int h, input int l);
      mon.CLK_IN = 1'b1;
      repeat (h) tick();
      mon.CLK_IN = 1'b0;
      repeat (l) tick();
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      mon.CLK_IN = 1'b0;
      repeat (3) tick();
      n_chk++; if (mon.RISE_CE !== 1'b0)      $display("FAIL rst_rise_ce: got %b want 0", mon.RISE_CE); else n_pass++;
      n_chk++; if (mon.FALL_CE !== 1'b0)      $display("FAIL rst_fall_ce: got %b want 0", mon.FALL_CE); else n_pass++;
      n_chk++; if (mon.PERIOD !== 8'd0)       $display("FAIL rst_period: got %0d want 0", mon.PERIOD); else n_pass++;
      n_chk++; if (mon.HIGH_TIME !== 8'd0)    $display("FAIL rst_high_time: got %0d want 0", mon.HIGH_TIME); else n_pass++;
      n_chk++; if (mon.PERIOD_VALID !== 1'b0) $display("FAIL rst_valid: got %b want 0", mon.PERIOD_VALID); else n_pass++;
      n_chk++; if (mon.LOCKED !== 1'b0)       $display("FAIL rst_locked: got %b want 0", mon.LOCKED); else n_pass++;
      n_chk++; if (mon.LOST !== 1'b0)         $display("FAIL rst_lost: got %b want 0", mon.LOST); else n_pass++;
      RESET = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_steady();
      clear_rec();
      repeat (8) drive_period(5, 5);
      n_chk++; if (rise_n !== 8) $display("FAIL steady_rise_count: got %0d want 8", rise_n); else n_pass++;
      for (int k = 1; k < 8; k++) begin
         n_chk++;
         if (rise_cyc[k] - rise_cyc[k-1] !== 10)
            $display("FAIL steady_rise_spacing[%0d]: got %0d want 10", k, rise_cyc[k] - rise_cyc[k-1]);
         else n_pass++;
      end
      n_chk++; if (rise_valid[0] !== 1'b0)   $display("FAIL steady_valid_r1: got %b want 0", rise_valid[0]); else n_pass++;
      n_chk++; if (rise_period[1] !== 8'd10) $display("FAIL steady_period_r2: got %0d want 10", rise_period[1]); else n_pass++;
      n_chk++; if (rise_valid[1] !== 1'b1)   $display("FAIL steady_valid_r2: got %b want 1", rise_valid[1]); else n_pass++;
      n_chk++; if (fall_high[1] !== 8'd5)    $display("FAIL steady_high_time: got %0d want 5", fall_high[1]); else n_pass++;
      n_chk++; if (fall_dt[1] !== 5)         $display("FAIL steady_fall_delay: got %0d want 5", fall_dt[1]); else n_pass++;
      n_chk++; if (rise_locked[4] !== 1'b0)  $display("FAIL steady_locked_r5: got %b want 0", rise_locked[4]); else n_pass++;
      n_chk++; if (rise_locked[5] !== 1'b1)  $display("FAIL steady_locked_r6: got %b want 1", rise_locked[5]); else n_pass++;
   endtask

   task automatic test_jitter();
      clear_rec();
      drive_period(5, 5);
      drive_period(5, 6);
      drive_period(5, 5);
      drive_period(5, 4);
      drive_period(5, 9);
      repeat (4) drive_period(5, 9);
      drive_period(5, 5);
      for (int k = 1; k <= 4; k++) begin
         n_chk++;
         if (rise_locked[k] !== 1'b1) $display("FAIL jitter_locked_hold[%0d]: got %b want 1", k, rise_locked[k]);
         else n_pass++;
      end
      n_chk++; if (rise_period[2] !== 8'd11) $display("FAIL jitter_period_11: got %0d want 11", rise_period[2]); else n_pass++;
      n_chk++; if (rise_period[4] !== 8'd9)  $display("FAIL jitter_period_9: got %0d want 9", rise_period[4]); else n_pass++;
      n_chk++; if (rise_period[5] !== 8'd14) $display("FAIL jitter_period_14: got %0d want 14", rise_period[5]); else n_pass++;
      n_chk++; if (rise_locked[5] !== 1'b0)  $display("FAIL jitter_unlock: got %b want 0", rise_locked[5]); else n_pass++;
      n_chk++; if (rise_locked[8] !== 1'b0)  $display("FAIL jitter_relock_early: got %b want 0", rise_locked[8]); else n_pass++;
      n_chk++; if (rise_locked[9] !== 1'b1)  $display("FAIL jitter_relock: got %b want 1", rise_locked[9]); else n_pass++;
   endtask

   task automatic test_loss();
      int   last_rise;
      int   lost_dt;
      logic lost_locked;
      logic lost_valid;
      last_rise   = rise_cyc[rise_n-1];
      lost_dt     = -1;
      lost_locked = 1'bx;
      lost_valid  = 1'bx;
      mon.CLK_IN  = 1'b0;
      n_chk++; if (mon.LOST !== 1'b0) $display("FAIL loss_early: got %b want 0", mon.LOST); else n_pass++;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (mon.LOST === 1'b1) begin
            lost_dt     = cyc - last_rise;
            lost_locked = mon.LOCKED;
            lost_valid  = mon.PERIOD_VALID;
            break;
         end
      end
      n_chk++; if (lost_dt !== 256)       $display("FAIL loss_delay: got %0d want 256", lost_dt); else n_pass++;
      n_chk++; if (lost_locked !== 1'b0)  $display("FAIL loss_locked: got %b want 0", lost_locked); else n_pass++;
      n_chk++; if (lost_valid !== 1'b0)   $display("FAIL loss_valid: got %b want 0", lost_valid); else n_pass++;
      n_chk++; if (mon.PERIOD !== 8'd14)  $display("FAIL loss_period_kept: got %0d want 14", mon.PERIOD); else n_pass++;
      n_chk++; if (mon.HIGH_TIME !== 8'd5) $display("FAIL loss_high_kept: got %0d want 5", mon.HIGH_TIME); else n_pass++;
      // Recovery at period 10.
      clear_rec();
      repeat (3) drive_period(5, 5);
      n_chk++; if (rise_lost[0] !== 1'b0)    $display("FAIL recover_lost: got %b want 0", rise_lost[0]); else n_pass++;
      n_chk++; if (rise_valid[0] !== 1'b0)   $display("FAIL recover_valid_r1: got %b want 0", rise_valid[0]); else n_pass++;
      n_chk++; if (rise_valid[1] !== 1'b1)   $display("FAIL recover_valid_r2: got %b want 1", rise_valid[1]); else n_pass++;
      n_chk++; if (rise_period[1] !== 8'd10) $display("FAIL recover_period: got %0d want 10", rise_period[1]); else n_pass++;
   endtask

   task automatic test_reset_mid();
      repeat (4) drive_period(5, 5);
      n_chk++; if (rise_locked[4] !== 1'b0) $display("FAIL midrst_prelock_r5: got %b want 0", rise_locked[4]); else n_pass++;
      n_chk++; if (rise_locked[5] !== 1'b1) $display("FAIL midrst_prelock_r6: got %b want 1", rise_locked[5]); else n_pass++;
      n_chk++; if (mon.LOCKED !== 1'b1)     $display("FAIL midrst_locked_before: got %b want 1", mon.LOCKED); else n_pass++;
      #3;
      RESET      = 1'b1;
      mon.CLK_IN = 1'b1;
      #1;
      n_chk++;
      if ({mon.RISE_CE, mon.FALL_CE, mon.PERIOD, mon.HIGH_TIME, mon.PERIOD_VALID, mon.LOCKED, mon.LOST} !== 21'd0)
         $display("FAIL midrst_async_clear: got period=%0d high=%0d valid=%b locked=%b lost=%b want all 0",
                  mon.PERIOD, mon.HIGH_TIME, mon.PERIOD_VALID, mon.LOCKED, mon.LOST);
      else n_pass++;
      tick();
      tick();
      RESET = 1'b0;
      clear_rec();
      repeat (2) drive_period(5, 5);
      n_chk++; if (rise_n !== 2)             $display("FAIL midrst_rise_count: got %0d want 2", rise_n); else n_pass++;
      n_chk++; if (rise_period[0] !== 8'd0)  $display("FAIL midrst_spurious_period: got %0d want 0", rise_period[0]); else n_pass++;
      n_chk++; if (rise_valid[0] !== 1'b0)   $display("FAIL midrst_spurious_valid: got %b want 0", rise_valid[0]); else n_pass++;
      n_chk++; if (rise_period[1] !== 8'd10) $display("FAIL midrst_period_r2: got %0d want 10", rise_period[1]); else n_pass++;
   endtask

   task automatic test_min_period();
      RESET      = 1'b1;
      mon.CLK_IN = 1'b0;
      tick();
      tick();
      RESET = 1'b0;
      repeat (3) tick();
      clear_rec();
      repeat (8) drive_period(2, 2);
      n_chk++; if (rise_n !== 8)                       $display("FAIL min_rise_count: got %0d want 8", rise_n); else n_pass++;
      n_chk++; if (rise_cyc[7] - rise_cyc[6] !== 4)    $display("FAIL min_rise_spacing: got %0d want 4", rise_cyc[7] - rise_cyc[6]); else n_pass++;
      n_chk++; if (rise_period[1] !== 8'd4)            $display("FAIL min_period: got %0d want 4", rise_period[1]); else n_pass++;
      n_chk++; if (rise_valid[1] !== 1'b1)             $display("FAIL min_valid: got %b want 1", rise_valid[1]); else n_pass++;
      n_chk++; if (fall_high[1] !== 8'd2)              $display("FAIL min_high_time: got %0d want 2", fall_high[1]); else n_pass++;
      n_chk++; if (rise_locked[4] !== 1'b0)            $display("FAIL min_locked_r5: got %b want 0", rise_locked[4]); else n_pass++;
      n_chk++; if (rise_locked[5] !== 1'b1)            $display("FAIL min_locked_r6: got %b want 1", rise_locked[5]); else n_pass++;
   endtask

   task automatic test_duty();
      clear_rec();
      repeat (4) drive_period(3, 7);
      n_chk++; if (rise_period[1] !== 8'd10) $display("FAIL duty_period_r2: got %0d want 10", rise_period[1]); else n_pass++;
      n_chk++; if (rise_period[2] !== 8'd10) $display("FAIL duty_period_r3: got %0d want 10", rise_period[2]); else n_pass++;
      n_chk++; if (fall_high[1] !== 8'd3)    $display("FAIL duty_high_r2: got %0d want 3", fall_high[1]); else n_pass++;
      n_chk++; if (fall_high[2] !== 8'd3)    $display("FAIL duty_high_r3: got %0d want 3", fall_high[2]); else n_pass++;
      n_chk++; if (fall_dt[1] !== 3)         $display("FAIL duty_fall_delay_r2: got %0d want 3", fall_dt[1]); else n_pass++;
      n_chk++; if (fall_dt[2] !== 3)         $display("FAIL duty_fall_delay_r3: got %0d want 3", fall_dt[2]); else n_pass++;
   endtask

   initial begin
      RESET      = 1'b1;
      mon.CLK_IN = 1'b0;
      clear_rec();
      test_reset();
      test_steady();
      test_jitter();
      test_loss();
      test_reset_mid();
      test_min_period();
      test_duty();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
